// File: rtl/vga_raster_pkg.sv
// vga_raster_pkg: default 640x480@60 timing, tile geometry and tile bit indexing
package vga_raster_pkg;
  localparam int CLK_DIV_D = 2;
  localparam int H_VISIBLE_D = 640;
  localparam int H_FRONT_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BACK_D = 48;
  localparam int V_VISIBLE_D = 480;
  localparam int V_FRONT_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BACK_D = 33;
  localparam int H_TOTAL_D = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
  localparam int V_TOTAL_D = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
  localparam int TILE_COLS = 4;
  localparam int TILE_ROWS = 2;
  localparam int TILE_W_D = H_VISIBLE_D / TILE_COLS;
  localparam int TILE_H_D = V_VISIBLE_D / TILE_ROWS;
  function automatic logic [2:0] tile_idx(input logic row, input logic [1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/vga_raster_out_if.sv
// vga_raster_out_if: framebuffer input and VGA pin bundle
interface vga_raster_out_if;
  logic [7:0] framebuffer;
  logic vga_hsync;
  logic vga_vsync;
  logic vga_r;
  logic vga_g;
  logic vga_b;
  modport master(input framebuffer, output vga_hsync, vga_vsync, vga_r, vga_g, vga_b);
  modport slave(output framebuffer, input vga_hsync, vga_vsync, vga_r, vga_g, vga_b);
endinterface

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: pixel divider, raster counters and active-low sync decode
module vga_sync_counter
  import vga_raster_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_D,
  parameter int H_VISIBLE = H_VISIBLE_D,
  parameter int H_FRONT = H_FRONT_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BACK = H_BACK_D,
  parameter int V_VISIBLE = V_VISIBLE_D,
  parameter int V_FRONT = V_FRONT_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BACK = V_BACK_D,
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          pix_tick,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          visible,
  output logic          hsync_n,
  output logic          vsync_n
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  logic h_last;
  assign pix_tick = div == DW'(CLK_DIV - 1);
  assign h_last = h_cnt == HW'(H_TOTAL - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      div <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      div <= pix_tick ? '0 : div + 1'b1;
      if (pix_tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) v_cnt <= v_cnt == VW'(V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
      end
    end
  end
  // compared as int so a sync window ending exactly at the total cannot overflow the counter width
  assign visible = int'(h_cnt) < H_VISIBLE && int'(v_cnt) < V_VISIBLE;
  assign hsync_n = !(int'(h_cnt) >= H_VISIBLE + H_FRONT && int'(h_cnt) < H_VISIBLE + H_FRONT + H_SYNC);
  assign vsync_n = !(int'(v_cnt) >= V_VISIBLE + V_FRONT && int'(v_cnt) < V_VISIBLE + V_FRONT + V_SYNC);
endmodule

// File: rtl/vga_raster_out.sv
// vga_raster_out: 4x2 tile raster from a per-frame shadowed 8-bit framebuffer
module vga_raster_out
  import vga_raster_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_D,
  parameter int H_VISIBLE = H_VISIBLE_D,
  parameter int H_FRONT = H_FRONT_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BACK = H_BACK_D,
  parameter int V_VISIBLE = V_VISIBLE_D,
  parameter int V_FRONT = V_FRONT_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BACK = V_BACK_D,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input logic clock,
  input logic reset,
  vga_raster_out_if.master bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int TILE_W = H_VISIBLE / TILE_COLS;
  localparam int TILE_H = V_VISIBLE / TILE_ROWS;
  logic pix_tick, visible, hsync_n, vsync_n, row, pix;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0] col;
  logic [7:0] shadow;
  vga_sync_counter #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_sync (
    .clock(clock), .reset(reset), .pix_tick(pix_tick), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .visible(visible), .hsync_n(hsync_n), .vsync_n(vsync_n)
  );
  always_comb begin
    col = int'(h_cnt) >= 3 * TILE_W ? 2'd3 : int'(h_cnt) >= 2 * TILE_W ? 2'd2 : int'(h_cnt) >= TILE_W ? 2'd1 : 2'd0;
    row = int'(v_cnt) >= TILE_H;
    pix = visible & shadow[tile_idx(row, col)];
  end
  // capture on the first blank line so the whole visible frame sees one value
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= '0;
      bus.vga_hsync <= !SYNC_ACTIVE;
      bus.vga_vsync <= !SYNC_ACTIVE;
      bus.vga_r <= 1'b0;
      bus.vga_g <= 1'b0;
      bus.vga_b <= 1'b0;
    end else begin
      if (pix_tick && h_cnt == '0 && int'(v_cnt) == V_VISIBLE) shadow <= bus.framebuffer;
      bus.vga_hsync <= hsync_n ^ SYNC_ACTIVE;
      bus.vga_vsync <= vsync_n ^ SYNC_ACTIVE;
      bus.vga_r <= pix;
      bus.vga_g <= pix;
      bus.vga_b <= pix;
    end
  end
endmodule

// File: doc/vga_raster_out.md
Name: vga_raster_out

Overview:
Downstream display stage for the VGA instruction block. Consumes its 8-bit framebuffer register and drives a 640x480@60 VGA raster with a 1-bit-per-channel DAC. The screen is split into a 4x2 tile grid; each framebuffer bit paints one tile white (1) or black (0). The framebuffer is shadowed once per frame at the start of vertical blanking, so the picture never tears.

Parameters:
CLK_DIV, 2, system clocks per pixel (50 MHz clock -> 25 MHz pixel rate); legal values >=1
H_VISIBLE, 640, visible pixels per line; must be divisible by 4
H_FRONT, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BACK, 48, horizontal back porch in pixels
V_VISIBLE, 480, visible lines per frame; must be divisible by 2
V_FRONT, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BACK, 33, vertical back porch in lines
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clock  in  1  system clock
reset  in  1  reset
framebuffer  in  8  tile bits from the instruction block; bit index = row*4 + col
vga_hsync  out  1  horizontal sync
vga_vsync  out  1  vertical sync
vga_r  out  1  red
vga_g  out  1  green
vga_b  out  1  blue

Behaviour:
- Interface (decided): reset reset, synchronous, active-high; clock clock.
- Pixel tick: a divider counts 0..CLK_DIV-1 and the tick asserts when it reaches CLK_DIV-1. With CLK_DIV=1 the tick is always asserted.
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Counters: h_cnt advances 0..H_TOTAL-1 on each tick and wraps to 0. v_cnt advances only on the tick where h_cnt wraps, and itself wraps from V_TOTAL-1 to 0.
- Counter widths: ceil(log2(total)) bits. Arithmetic is unsigned, with no overflow past a total.
- Sync assertion:
  - hsync asserted iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (pixels 656..751).
  - vsync asserted iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (lines 490..491).
- Visible region: h_cnt < H_VISIBLE and v_cnt < V_VISIBLE. Outside it, r/g/b are 0.
- Tile select: col = 0..3 from comparing h_cnt against multiples of H_VISIBLE/4 (160), with no divider. row = 0 if v_cnt < V_VISIBLE/2 (240), else 1.
- Pixel value: pix = shadow[row*4+col]; vga_r = vga_g = vga_b = pix.
- Shadow capture: shadow <= framebuffer on the tick where h_cnt=0 and v_cnt=V_VISIBLE (first blank line). Changes to framebuffer at any other time have no visible effect until the next capture.
- Latency: all five outputs are registered, updating on the clock edge after the counter values they reflect. This gives a fixed 1-clock offset between counters and outputs, identical for sync and colour so pixel alignment holds. Outputs hold their value between ticks.
- Reset, applied at any time including mid-line or mid-frame:
  - divider, h_cnt, v_cnt and shadow go to 0;
  - vga_hsync and vga_vsync go to ~SYNC_ACTIVE (inactive);
  - vga_r, vga_g, vga_b go to 0.
- After reset, the first frame is black; the first capture happens at line 480 of frame 0.
- framebuffer is synchronous to clock, so no CDC logic is needed.

Decomposition:
- Package vga_raster_pkg holds:
  - the default timing constants and derived H_TOTAL/V_TOTAL;
  - localparams for tile width/height;
  - the bit-index function row*4+col.
- One sub-module, vga_sync_counter, contains the divider, h_cnt, v_cnt and sync compare, and exposes pix_tick, h_cnt, v_cnt, visible, hsync_n and vsync_n. The top level adds the shadow register, tile decode and output registers.

Test Plan:
- Reset, then free-run 1600 clocks (CLK_DIV=2) -> vga_hsync low for exactly 192 clocks, starting 1312 clocks (pixel 656) plus 1 clock after line start; period 1600 clocks.
- Free-run two frames -> vsync low for exactly 2 lines (3200 clocks) starting at line 490; frame period 840000 clocks.
- framebuffer=8'b1000_0001 held from reset -> frame 0 all black. Frame 1: tile (row0,col0), i.e. pixels 0..159 on lines 0..239, is white. Tile (row1,col3), i.e. pixels 480..639 on lines 240..479, is white. Every other tile and all blanking is black.
- Change framebuffer from 8'hFF to 8'h00 mid-frame at line 100 -> the rest of the frame stays as previously captured; the change appears only from the next frame start.
- Assert reset for 1 clock at line 300, pixel 400 -> next clock: syncs high, rgb 0, counters 0; the next hsync falls 1312+1 clocks later.
- CLK_DIV=1 build -> hsync low 96 clocks, line period 800 clocks; tile boundaries at clocks 160/320/480 after line start, plus 1.
